// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider for MIPS32 DIV/DIVU: quotient to LO (quo), remainder to HI (rem).
// Optional build macro DIV_EARLY_OUT_EN skips the iteration loop when |x| < |y|.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_dbz;
  logic [WIDTH-1:0] r_quo, r_rem;
  logic [WIDTH-1:0] r_dvd, r_prem, r_dvs;
  logic             r_neg_q, r_neg_r, r_bypass, r_yzero;

  logic [WIDTH-1:0] w_xmag, w_ymag;
  logic             w_y_zero, w_early, w_accept, w_qbit;
  logic [WIDTH:0]   w_shift;

  // Magnitude as an unsigned WIDTH-bit value, so the most-negative operand stays exact.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign w_xmag   = mag(x, is_signed);
  assign w_ymag   = mag(y, is_signed);
  assign w_y_zero = (y == '0);
  assign w_accept = start && (r_state == IDLE);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_y_zero && (w_xmag < w_ymag);
`else
  assign w_early = 1'b0;
`endif

  // Trial subtraction at WIDTH+1 bits: the shifted remainder can exceed WIDTH bits.
  assign w_shift = {r_prem, r_dvd[WIDTH-1]};
  assign w_qbit  = (w_shift >= {1'b0, r_dvs});

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign quo         = r_quo;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (w_y_zero || w_early) ? FIX : CALC;
      CALC:    if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      if (w_accept) begin
        r_cnt <= '0;
        r_dbz <= 1'b0;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Bypassed ops (zero divisor, early-out) carry their final result unmodified.
      if (r_state == FIX) begin
        r_quo <= r_bypass ? r_dvd  : cneg(r_dvd, r_neg_q);
        r_rem <= r_bypass ? r_prem : cneg(r_prem, r_neg_r);
        r_dbz <= r_yzero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg_q <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg_r <= is_signed & x[WIDTH-1];
      r_dvs   <= w_ymag;
      r_yzero <= w_y_zero;
      if (w_y_zero) begin
        r_dvd    <= '1;
        r_prem   <= x;
        r_bypass <= 1'b1;
      end else if (w_early) begin
        r_dvd    <= '0;
        r_prem   <= x;
        r_bypass <= 1'b1;
      end else begin
        r_dvd    <= w_xmag;
        r_prem   <= '0;
        r_bypass <= 1'b0;
      end
    end else if (r_state == CALC) begin
      r_prem <= w_qbit ? WIDTH'(w_shift - {1'b0, r_dvs}) : w_shift[WIDTH-1:0];
      r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
    end
  end

endmodule
